// File: rtl/seq_detect_pkg.sv
// Shared types and defaults for the runtime-programmable sequence detector.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } state_t;

  localparam int DEF_MAX_LEN     = 8;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_TIMEOUT_CYC = 64;

  // Width needed to hold a pattern length of 0..max_len inclusive.
  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Match-event handshake between the detector (master) and its consumer (slave).
interface seq_detect_ctrl_if #(
  parameter int CNT_W = 8
) ();

  logic             evt_valid;
  logic [CNT_W-1:0] evt_idx;
  logic             evt_ack;
  logic             evt_ovf;

  modport master (output evt_valid, output evt_idx, output evt_ovf, input evt_ack);
  modport slave  (input evt_valid, input evt_idx, input evt_ovf, output evt_ack);

endinterface

// File: rtl/seq_window_match.sv
// Shift window, fill counter and length-masked compare; hit is evaluated on the
// window as it will look after the current bit is shifted in.
module seq_window_match
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = len_w(DEF_MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift,
  input  logic               clear,
  input  logic               x,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               full,
  output logic               hit
);

  logic [MAX_LEN-1:0] window_q;
  logic [MAX_LEN-1:0] window_d;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_q;
  logic [LEN_W-1:0]   fill_d;

  assign window_d = {window_q[MAX_LEN-2:0], x};
  assign fill_d   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
  end

  assign full = (fill_d >= len);
  assign hit  = full && (((window_d ^ pattern) & mask) == '0);

  // Clear wins over shift so a non-overlapping match restarts from an empty window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      window_q <= '0;
      fill_q   <= '0;
    end else if (clear) begin
      window_q <= '0;
      fill_q   <= '0;
    end else if (shift) begin
      window_q <= window_d;
      fill_q   <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequence detector controller: config regs, FSM, match counter, event handshake.
// Optional auto-disarm on inactivity when SEQ_DETECT_TIMEOUT_EN is defined.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  localparam int LEN_W  = len_w(MAX_LEN),
  parameter int CNT_W   = DEF_CNT_W
`ifdef SEQ_DETECT_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [MAX_LEN-1:0]  cfg_pattern,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic                cfg_overlap,
  input  logic                arm,
  input  logic                disarm,
  input  logic                x,
  input  logic                x_valid,
  output logic                busy,
  output logic                match,
  output logic [CNT_W-1:0]    match_cnt,
  output logic                cfg_err,
  seq_detect_ctrl_if.master   evt
`ifdef SEQ_DETECT_TIMEOUT_EN
  , output logic              timeout
`endif
);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   cnt_q, cnt_inc, idx_q;
  logic               match_q, err_q, evt_valid_q, ovf_q;
  logic               start, sample, match_now, win_clear;
  logic               cfg_ok, cfg_load, full, hit, timeout_now;

  assign busy      = (state_q != IDLE);
  assign start     = (state_q == IDLE) && arm && !disarm;
  assign sample    = busy && x_valid && !disarm;
  assign match_now = sample && hit;
  assign win_clear = start || (match_now && !ovl_q);
  assign cfg_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign cfg_load  = cfg_we && (state_q == IDLE) && cfg_ok;
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  seq_window_match #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk     (clk),
    .reset   (reset),
    .shift   (sample),
    .clear   (win_clear),
    .x       (x),
    .pattern (pat_q),
    .len     (len_q),
    .full    (full),
    .hit     (hit)
  );

`ifdef SEQ_DETECT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] idle_q;
  logic            timeout_q;

  assign timeout_now = busy && !disarm && !match_now && (idle_q == TO_W'(TIMEOUT_CYC - 1));
  assign timeout     = timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_now;
      if (start || match_now || !busy || timeout_now) idle_q <= '0;
      else idle_q <= idle_q + 1'b1;
    end
  end
`else
  assign timeout_now = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = FILL;
      FILL, HUNT: begin
        if (disarm || timeout_now)   state_d = IDLE;
        else if (match_now)          state_d = ovl_q ? HUNT : FILL;
        else if (sample && full)     state_d = HUNT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q <= '0;
      len_q <= LEN_W'(1);
      ovl_q <= 1'b0;
    end else if (cfg_load) begin
      pat_q <= cfg_pattern;
      len_q <= cfg_len;
      ovl_q <= cfg_overlap;
    end
  end

  // A match always counts; only the event slot can be lost if the consumer is slow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      evt_valid_q <= 1'b0;
      idx_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      match_q <= match_now;
      err_q   <= cfg_we && !cfg_load;
      if (start) cnt_q <= '0;
      else if (match_now) cnt_q <= cnt_inc;
      if (start) ovf_q <= 1'b0;
      else if (match_now && evt_valid_q && !evt.evt_ack) ovf_q <= 1'b1;
      if (match_now && (!evt_valid_q || evt.evt_ack)) begin
        evt_valid_q <= 1'b1;
        idx_q       <= cnt_inc;
      end else if (evt_valid_q && evt.evt_ack) begin
        evt_valid_q <= 1'b0;
      end
    end
  end

  assign match         = match_q;
  assign match_cnt     = cnt_q;
  assign cfg_err       = err_q;
  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_idx   = idx_q;
  assign evt.evt_ovf   = ovf_q;

endmodule
